piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in/serial-out stage placed directly upstream of the serial pattern detectors (e.g. the 1011 detector).
- Accepts a WIDTH-bit word over a valid/ready handshake and drives it one bit per clock onto a serial line that feeds the detector's din.
- Supports back-to-back words with no idle bubble between them, so multi-word bit streams reach the detector contiguously.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = shift bit WIDTH-1 first; 0 = shift bit 0 first.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- load_valid  input  1  upstream word available.
- load_data  input  WIDTH  word to serialize; sampled only on an accept.
- load_ready  output  1  serializer can accept a word this cycle.
- sdout  output  1  serial data bit (connects to detector din).
- sdout_valid  output  1  sdout carries a real data bit this cycle.
- last_bit  output  1  high during the final serial bit of a word.
- busy  output  1  a word is being shifted out.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; shift register 0; bit counter 0; sdout=0, sdout_valid=0, last_bit=0, busy=0. load_ready is forced 0 while reset is low.
- States: IDLE, SHIFT.
- Accept condition: load_valid && load_ready at a rising clk edge.
- load_ready (combinational):
  - 1 in IDLE.
  - 1 in SHIFT only when the counter indicates the last bit.
  - 0 otherwise.
- IDLE -> SHIFT on accept.
  - load_data is captured and the counter cleared.
  - The first bit appears on sdout in the cycle after the accepting edge (latency 1).
- SHIFT:
  - Each cycle presents one bit on sdout with sdout_valid=1 and busy=1.
  - Counter increments 0..N-1, where N=WIDTH (or WIDTH+1 with parity, see Optional Feature).
  - last_bit=1 when counter=N-1.
- On the last bit:
  - Accept: reload the register, clear the counter, remain in SHIFT. The next cycle carries bit 0 of the new word (no gap).
  - No accept: go to IDLE.
- IDLE outputs: sdout=0, sdout_valid=0, busy=0, last_bit=0. Idle line level is 0 so the detector sees zeros.
- Bit order:
  - MSB_FIRST=1 sends load_data[WIDTH-1] first, ending with load_data[0].
  - MSB_FIRST=0 sends the reverse order.
- load_data and load_valid are ignored whenever load_ready=0. Upstream must hold load_valid/load_data stable until the accept.
- A word is never truncated or altered except by reset.
- Reset mid-word: outputs return to reset values immediately (asynchronously). The partial word is discarded; no bits resume after reset releases.
- Total latency: a word occupies exactly N consecutive sdout_valid cycles.
- Throughput: one word per N cycles when load_valid is held high.

Optional Feature:
- Macro: SERIALIZER_PARITY_EN.
- When defined:
  - N=WIDTH+1.
  - After the last data bit, one extra bit is driven: the even-parity bit, which is the XOR of all WIDTH captured data bits.
  - last_bit and the load_ready window move to this parity cycle; sdout_valid=1 for it.
- When undefined:
  - N=WIDTH.
  - No parity logic is generated, and last_bit marks data bit 0 (MSB_FIRST=1) or bit WIDTH-1 (MSB_FIRST=0).

Test Plan:
1. WIDTH=8, MSB_FIRST=1. Hold reset=0 for 2 cycles, release, then accept 8'hB0 once. Required: sdout=1,0,1,1,0,0,0,0 over 8 cycles starting the cycle after the accept; sdout_valid high for exactly those 8 cycles; last_bit high only on cycle 8; then IDLE with sdout=0.
2. Back-to-back: load_valid held high with 8'hB0, then 8'h0D presented and accepted during last_bit of the first word. Required: 16 consecutive sdout_valid cycles with stream 1011_0000_0000_1101 and no gap; load_ready high only in IDLE and on the two last-bit cycles.
3. MSB_FIRST=0, accept 8'h0D. Required: sdout=1,0,1,1,0,0,0,0; busy deasserts the cycle after last_bit.
4. Assert reset=0 asynchronously mid-clock after the 3rd bit of 8'hFF. Required: sdout, sdout_valid and busy drop to 0 immediately, no remaining bits are emitted after release, and the next accepted word serializes from bit 0.
5. load_valid pulsed while busy and not on the last bit, with data 8'hAA. Required: not accepted; the current word completes unchanged; load_ready stays 0.
6. SERIALIZER_PARITY_EN defined, accept 8'hB0 (three ones). Required: 9 valid cycles with stream 1,0,1,1,0,0,0,0,1 and last_bit on cycle 9. Repeat with 8'h0F: parity bit 0.

Source files
------------

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, one bit per clock serial-out.
// Optional even-parity trailer bit when SERIALIZER_PARITY_EN is defined.
module piso_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    output logic             load_ready,
    output logic             sdout,
    output logic             sdout_valid,
    output logic             last_bit,
    output logic             busy
);

`ifdef SERIALIZER_PARITY_EN
    localparam int N = WIDTH + 1;
`else
    localparam int N = WIDTH;
`endif
    localparam int CW = $clog2(N);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_nxt;
    logic [WIDTH-1:0] sreg_shl;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             at_last;
    logic             accept;
    logic             head;

    assign at_last = (state == SHIFT) && (cnt == CW'(N - 1));

    // Window is gated by reset so nothing is handshaken while held.
    assign load_ready = reset && ((state == IDLE) || at_last);
    assign accept     = load_valid && load_ready;

    assign busy        = (state == SHIFT);
    assign sdout_valid = (state == SHIFT);
    assign last_bit    = at_last;

    generate
        if (MSB_FIRST) begin : g_msb
            assign head     = sreg[WIDTH-1];
            assign sreg_shl = {sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head     = sreg[0];
            assign sreg_shl = {1'b0, sreg[WIDTH-1:1]};
        end
    endgenerate

`ifdef SERIALIZER_PARITY_EN
    logic par_q;
    logic par_nxt;

    always_comb begin
        par_nxt = par_q;
        if (accept) begin
            par_nxt = ^load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_nxt;
        end
    end

    // The final cycle of a word carries the parity bit, not data.
    assign sdout = (state == SHIFT) && (at_last ? par_q : head);
`else
    assign sdout = (state == SHIFT) && head;
`endif

    always_comb begin
        state_nxt = state;
        sreg_nxt  = sreg;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                    sreg_nxt  = load_data;
                    cnt_nxt   = '0;
                end
            end
            SHIFT: begin
                if (at_last) begin
                    cnt_nxt = '0;
                    if (accept) begin
                        sreg_nxt = load_data;
                    end else begin
                        state_nxt = IDLE;
                        sreg_nxt  = '0;
                    end
                end else begin
                    cnt_nxt  = cnt + CW'(1);
                    sreg_nxt = sreg_shl;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            sreg  <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sreg  <= sreg_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench for an MSB-first and an LSB-first
// 8-bit serializer; expected bits are queued at load time.
module tb_piso_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int N = 8 + PAR;

    typedef struct packed {
        logic b;
        logic last;
    } exp_t;

    logic            clk;
    logic            reset;
    logic [1:0]      lv;
    logic [1:0][7:0] ld;
    logic [1:0]      lr;
    logic [1:0]      sd;
    logic [1:0]      sv;
    logic [1:0]      lb;
    logic [1:0]      bz;

    exp_t q[$];
    int   nchk;
    int   nfail;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .reset(reset),
        .load_valid(lv[0]), .load_data(ld[0]), .load_ready(lr[0]),
        .sdout(sd[0]), .sdout_valid(sv[0]), .last_bit(lb[0]), .busy(bz[0])
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .reset(reset),
        .load_valid(lv[1]), .load_data(ld[1]), .load_ready(lr[1]),
        .sdout(sd[1]), .sdout_valid(sv[1]), .last_bit(lb[1]), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic void push_word(input logic [7:0] d, input bit msb);
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            e.b    = msb ? d[7-i] : d[i];
            e.last = (i == 7) && (PAR == 0);
            q.push_back(e);
        end
        if (PAR == 1) begin
            e.b    = ^d;
            e.last = 1'b1;
            q.push_back(e);
        end
    endfunction

    task automatic test_reset;
        reset = 1'b0;
        lv = '0;
        ld = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            nchk++;
            if (lr[s] !== 1'b0 || sd[s] !== 1'b0 || sv[s] !== 1'b0 ||
                lb[s] !== 1'b0 || bz[s] !== 1'b0) begin
                nfail++;
                $display("FAIL reset_outputs dut%0d: got lr=%b sd=%b sv=%b lb=%b bz=%b, want all 0",
                         s, lr[s], sd[s], sv[s], lb[s], bz[s]);
            end
        end
        reset = 1'b1;
        #1;
        nchk++;
        if (lr !== 2'b11) begin
            nfail++;
            $display("FAIL ready_after_reset: got %b want 11", lr);
        end
    endtask

    task automatic test_word(input int s, input logic [7:0] d, input string tag);
        exp_t e;
        int   nv;
        nv = 0;
        @(negedge clk);
        nchk++;
        if (lr[s] !== 1'b1) begin
            nfail++;
            $display("FAIL %s idle_ready: got %b want 1", tag, lr[s]);
        end
        lv[s] = 1'b1;
        ld[s] = d;
        @(posedge clk);
        #1;
        lv[s] = 1'b0;
        push_word(d, s == 0);
        repeat (N + 2) begin
            @(negedge clk);
            if (sv[s]) begin
                nv++;
                nchk++;
                if (q.size() == 0) begin
                    nfail++;
                    $display("FAIL %s extra_bit: got valid bit %0d want none", tag, nv);
                end else begin
                    e = q.pop_front();
                    if (sd[s] !== e.b || lb[s] !== e.last ||
                        lr[s] !== e.last || bz[s] !== 1'b1) begin
                        nfail++;
                        $display("FAIL %s bit%0d: got sd=%b lb=%b lr=%b bz=%b want sd=%b lb=%b lr=%b bz=1",
                                 tag, nv, sd[s], lb[s], lr[s], bz[s], e.b, e.last, e.last);
                    end
                end
            end
        end
        nchk++;
        if (nv != N) begin
            nfail++;
            $display("FAIL %s valid_count: got %0d want %0d", tag, nv, N);
        end
        nchk++;
        if (sd[s] !== 1'b0 || bz[s] !== 1'b0 || lb[s] !== 1'b0 || lr[s] !== 1'b1) begin
            nfail++;
            $display("FAIL %s idle_after: got sd=%b bz=%b lb=%b lr=%b want 0 0 0 1",
                     tag, sd[s], bz[s], lb[s], lr[s]);
        end
        nchk++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL %s missing_bits: got %0d left want 0", tag, q.size());
        end
        q.delete();
    endtask

    task automatic test_single;
        test_word(0, 8'hB0, "single_b0");
    endtask

    task automatic test_lsb_first;
        test_word(1, 8'h0D, "lsb_0d");
    endtask

    task automatic test_parity;
        test_word(0, 8'hB0, "par_b0");
        test_word(0, 8'h0F, "par_0f");
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   nv;
        int   words;
        int   first;
        int   lastc;
        nv = 0;
        words = 1;
        first = -1;
        lastc = -1;
        @(negedge clk);
        lv[0] = 1'b1;
        ld[0] = 8'hB0;
        push_word(8'hB0, 1'b1);
        for (int c = 0; c < 2 * N + 4; c++) begin
            @(negedge clk);
            if (sv[0]) begin
                nv++;
                if (first < 0) first = c;
                lastc = c;
                nchk++;
                if (q.size() == 0) begin
                    nfail++;
                    $display("FAIL b2b extra_bit: got valid at cycle %0d want none", c);
                end else begin
                    e = q.pop_front();
                    if (sd[0] !== e.b || lb[0] !== e.last || lr[0] !== e.last) begin
                        nfail++;
                        $display("FAIL b2b bit%0d: got sd=%b lb=%b lr=%b want sd=%b lb=%b lr=%b",
                                 nv, sd[0], lb[0], lr[0], e.b, e.last, e.last);
                    end
                    if (e.last && words == 1) begin
                        ld[0] = 8'h0D;
                        push_word(8'h0D, 1'b1);
                        words = 2;
                    end else if (e.last) begin
                        lv[0] = 1'b0;
                    end
                end
            end else begin
                nchk++;
                if (lr[0] !== 1'b1 || sd[0] !== 1'b0) begin
                    nfail++;
                    $display("FAIL b2b idle: got lr=%b sd=%b want 1 0", lr[0], sd[0]);
                end
            end
        end
        lv[0] = 1'b0;
        nchk++;
        if (nv != 2 * N || lastc - first + 1 != 2 * N) begin
            nfail++;
            $display("FAIL b2b contiguous: got %0d valid over span %0d want %0d",
                     nv, lastc - first + 1, 2 * N);
        end
        nchk++;
        if (q.size() != 0) begin
            nfail++;
            $display("FAIL b2b missing_bits: got %0d left want 0", q.size());
        end
        q.delete();
    endtask

    task automatic test_mid_reset;
        int nv;
        nv = 0;
        @(negedge clk);
        lv[0] = 1'b1;
        ld[0] = 8'hFF;
        @(posedge clk);
        #1;
        lv[0] = 1'b0;
        while (nv < 3) begin
            @(negedge clk);
            if (sv[0]) nv++;
            nchk++;
            if (sv[0] !== 1'b1 || sd[0] !== 1'b1) begin
                nfail++;
                $display("FAIL mid_reset pre_bit%0d: got sv=%b sd=%b want 1 1", nv, sv[0], sd[0]);
                nv = 3;
            end
        end
        #2;
        reset = 1'b0;
        #1;
        nchk++;
        if (sd[0] !== 1'b0 || sv[0] !== 1'b0 || bz[0] !== 1'b0 || lr[0] !== 1'b0) begin
            nfail++;
            $display("FAIL mid_reset async: got sd=%b sv=%b bz=%b lr=%b want 0 0 0 0",
                     sd[0], sv[0], bz[0], lr[0]);
        end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        nv = 0;
        repeat (N + 2) begin
            @(negedge clk);
            if (sv[0]) nv++;
        end
        nchk++;
        if (nv != 0) begin
            nfail++;
            $display("FAIL mid_reset resumed: got %0d bits want 0", nv);
        end
        test_word(0, 8'h3C, "after_reset_3c");
    endtask

    task automatic test_reject_busy;
        exp_t e;
        int   nv;
        nv = 0;
        @(negedge clk);
        lv[0] = 1'b1;
        ld[0] = 8'hB0;
        @(posedge clk);
        #1;
        lv[0] = 1'b0;
        push_word(8'hB0, 1'b1);
        repeat (N + 3) begin
            @(negedge clk);
            if (sv[0]) begin
                nv++;
                nchk++;
                if (q.size() == 0) begin
                    nfail++;
                    $display("FAIL reject extra_bit: got bit %0d want none", nv);
                end else begin
                    e = q.pop_front();
                    if (sd[0] !== e.b || lr[0] !== e.last) begin
                        nfail++;
                        $display("FAIL reject bit%0d: got sd=%b lr=%b want sd=%b lr=%b",
                                 nv, sd[0], lr[0], e.b, e.last);
                    end
                end
                if (nv == 2) begin
                    lv[0] = 1'b1;
                    ld[0] = 8'hAA;
                end
                if (nv == 5) lv[0] = 1'b0;
            end
        end
        nchk++;
        if (nv != N || sv[0] !== 1'b0) begin
            nfail++;
            $display("FAIL reject count: got %0d valid sv=%b want %0d sv=0", nv, sv[0], N);
        end
        q.delete();
    endtask

    initial begin
        nchk = 0;
        nfail = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_lsb_first();
        test_mid_reset();
        test_reject_busy();
        test_parity();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
